// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - keypad lock front end with unlock hold, lockout and fire override
module lock_controller #(
    parameter int                    NUM_DIGITS     = 5,
    parameter logic [4*NUM_DIGITS-1:0] PASSWORD     = 20'h12345,
    parameter int                    MAX_TRIES      = 3,
    parameter int                    UNLOCK_CYCLES  = 500,
    parameter int                    LOCKOUT_CYCLES = 1000,
    localparam int                   CNT_W          = $clog2(NUM_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    input  logic             clear,
    input  logic             fire_alarm,
    output logic             unlock,
    output logic             err,
    output logic             locked_out,
    output logic [CNT_W-1:0] digit_cnt,
    output logic [3:0]       fail_cnt
);

    localparam int TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ENTRY   = 2'd1,
        S_OPEN    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] digit_cnt_q, digit_cnt_d;
    logic             mismatch_q, mismatch_d;
    logic [3:0]       fail_cnt_q, fail_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;

    logic [3:0]       expected_digit;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       fail_inc;
    logic             digit_miss;
    logic             entry_done;
    logic             entry_bad;
    logic             timer_last;

    // Pick the password nibble that the next press is compared against (first digit in the MS nibble)
    always_comb begin
        expected_digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_cnt_q == CNT_W'(i)) begin
                expected_digit = PASSWORD[4*(NUM_DIGITS-1-i) +: 4];
            end
        end
    end

    assign digit_miss = (digit != expected_digit);
    assign cnt_inc    = digit_cnt_q + 1'b1;
    assign entry_done = (cnt_inc == CNT_W'(NUM_DIGITS));
    // mismatch_q is always 0 in IDLE, so the same expression covers the first press
    assign entry_bad  = mismatch_q | digit_miss;
    // fail_cnt never wraps past MAX_TRIES
    assign fail_inc   = (fail_cnt_q < 4'(MAX_TRIES)) ? (fail_cnt_q + 4'd1) : fail_cnt_q;
    assign timer_last = (timer_q <= TMR_W'(1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            digit_cnt_q <= '0;
            mismatch_q  <= 1'b0;
            fail_cnt_q  <= 4'd0;
            timer_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            mismatch_q  <= mismatch_d;
            fail_cnt_q  <= fail_cnt_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
        end
    end

    // Next-state and datapath update; fire_alarm overrides everything
    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        mismatch_d  = mismatch_q;
        fail_cnt_d  = fail_cnt_q;
        timer_d     = timer_q;
        err_d       = 1'b0;

        if (fire_alarm) begin
            state_d     = S_IDLE;
            digit_cnt_d = '0;
            mismatch_d  = 1'b0;
            fail_cnt_d  = 4'd0;
            timer_d     = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (clear) begin
                        state_d     = S_IDLE;
                        digit_cnt_d = '0;
                        mismatch_d  = 1'b0;
                    end else if (digit_valid) begin
                        if (entry_done) begin
                            digit_cnt_d = '0;
                            mismatch_d  = 1'b0;
                            if (!entry_bad) begin
                                state_d    = S_OPEN;
                                timer_d    = TMR_W'(UNLOCK_CYCLES);
                                fail_cnt_d = 4'd0;
                            end else begin
                                err_d      = 1'b1;
                                fail_cnt_d = fail_inc;
                                if (fail_inc == 4'(MAX_TRIES)) begin
                                    state_d = S_LOCKOUT;
                                    timer_d = TMR_W'(LOCKOUT_CYCLES);
                                end else begin
                                    state_d = S_IDLE;
                                end
                            end
                        end else begin
                            state_d     = S_ENTRY;
                            digit_cnt_d = cnt_inc;
                            mismatch_d  = entry_bad;
                        end
                    end
                end
                S_OPEN: begin
                    timer_d = timer_q - 1'b1;
                    if (timer_last) begin
                        state_d = S_IDLE;
                    end
                end
                S_LOCKOUT: begin
                    timer_d = timer_q - 1'b1;
                    if (timer_last) begin
                        state_d    = S_IDLE;
                        fail_cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs: only unlock has a combinational path, from fire_alarm
    always_comb begin
        unlock     = (state_q == S_OPEN) | fire_alarm;
        err        = err_q;
        locked_out = (state_q == S_LOCKOUT);
        digit_cnt  = digit_cnt_q;
        fail_cnt   = fail_cnt_q;
    end

endmodule

// File: tb/tb_lock_controller.sv
// tb/tb_lock_controller.sv - randomized scoreboard bench for lock_controller
`timescale 1ns/1ps
module tb_lock_controller;

    localparam int N    = 5;
    localparam int U    = 500;
    localparam int L    = 1000;
    localparam int MAXT = 3;

    localparam int K_UNLOCK = 0;
    localparam int K_ERR    = 1;
    localparam int K_LOCK   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       clear = 1'b0;
    logic       fire_alarm = 1'b0;
    logic       unlock;
    logic       err;
    logic       locked_out;
    logic [2:0] digit_cnt;
    logic [3:0] fail_cnt;

    lock_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digit_valid (digit_valid),
        .digit       (digit),
        .clear       (clear),
        .fire_alarm  (fire_alarm),
        .unlock      (unlock),
        .err         (err),
        .locked_out  (locked_out),
        .digit_cnt   (digit_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int kind;
        int fail;
    } exp_t;

    exp_t sbq[$];

    // Reference model: whole-entry comparison against a digit list, busy windows by absolute edge index
    int pw[N] = '{1, 2, 3, 4, 5};
    int entry[$];
    int fail_m      = 0;
    int accept_from = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_reset();
        entry.delete();
        fail_m      = 0;
        accept_from = 0;
    endtask

    task automatic model_edge(input bit dv, input int d, input bit clr, input bit fa);
        int   e;
        bit   match;
        exp_t ex;
        e = cyc;
        if (fa) begin
            model_reset();
            return;
        end
        if (e < accept_from) return;
        if (clr) begin
            entry.delete();
            return;
        end
        if (!dv) return;
        entry.push_back(d);
        if (entry.size() == N) begin
            match = 1'b1;
            for (int i = 0; i < N; i++) if (entry[i] != pw[i]) match = 1'b0;
            if (match) begin
                ex.kind     = K_UNLOCK;
                ex.fail     = 0;
                fail_m      = 0;
                accept_from = e + U + 1;
            end else begin
                if (fail_m < MAXT) fail_m++;
                ex.fail = fail_m;
                if (fail_m == MAXT) begin
                    ex.kind     = K_LOCK;
                    fail_m      = 0;
                    accept_from = e + L + 1;
                end else begin
                    ex.kind = K_ERR;
                end
            end
            sbq.push_back(ex);
            entry.delete();
        end
    endtask

    task automatic step(input bit dv, input int d, input bit clr, input bit fa);
        digit_valid = dv;
        digit       = 4'(d);
        clear       = clr;
        fire_alarm  = fa;
        if (!rst_n) model_reset();
        else        model_edge(dv, d, clr, fa);
        @(posedge clk);
        #1;
        chk("digit_cnt", int'(digit_cnt), entry.size());
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic enter5(input logic [19:0] code);
        for (int i = 0; i < N; i++) step(1'b1, int'(code[4*(N-1-i) +: 4]), 1'b0, 1'b0);
    endtask

    // Edge counter used by the model's busy windows
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Monitor: pops the scoreboard on err pulses and unlock rises, and times unlock/lockout windows
    initial begin
        bit   open_now;
        bit   open_prev;
        bit   lock_prev;
        int   open_len;
        int   lock_len;
        int   kind_obs;
        exp_t ex;
        open_prev = 1'b0;
        lock_prev = 1'b0;
        open_len  = 0;
        lock_len  = 0;
        forever begin
            @(negedge clk);
            open_now = unlock && !fire_alarm;
            if (rst_n && err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_err", 1, 0);
                end else begin
                    ex = sbq.pop_front();
                    kind_obs = locked_out ? K_LOCK : K_ERR;
                    chk("err_kind", kind_obs, ex.kind);
                    chk("err_fail_cnt", int'(fail_cnt), ex.fail);
                end
            end
            if (open_now && !open_prev) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_unlock", 1, 0);
                end else begin
                    ex = sbq.pop_front();
                    chk("unlock_kind", K_UNLOCK, ex.kind);
                    chk("unlock_fail_cnt", int'(fail_cnt), 0);
                    chk("unlock_err", int'(err), 0);
                end
            end
            if (open_now) open_len = open_prev ? open_len + 1 : 1;
            if (!open_now && open_prev && rst_n && !fire_alarm) chk("unlock_len", open_len, U);
            if (locked_out) lock_len = lock_prev ? lock_len + 1 : 1;
            if (!locked_out && lock_prev && rst_n && !fire_alarm) begin
                chk("lockout_len", lock_len, L);
                chk("lockout_exit_fail_cnt", int'(fail_cnt), 0);
            end
            open_prev = open_now;
            lock_prev = locked_out;
        end
    end

    initial begin
        int r;
        int d;

        // Reset values, fire path live during reset
        rst_n      = 1'b0;
        fire_alarm = 1'b1;
        #1;
        chk("reset_unlock_fire", int'(unlock), 1);
        fire_alarm = 1'b0;
        #1;
        chk("reset_unlock", int'(unlock), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_locked_out", int'(locked_out), 0);
        chk("reset_digit_cnt", int'(digit_cnt), 0);
        chk("reset_fail_cnt", int'(fail_cnt), 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Correct entry on consecutive cycles
        enter5(20'h12345);
        chk("open_unlock_now", int'(unlock), 1);
        idle(U + 5);

        // One wrong entry then a correct one
        enter5(20'h12346);
        enter5(20'h12345);
        idle(U + 5);

        // Three wrong entries -> lockout, presses ignored during lockout
        enter5(20'h99999);
        enter5(20'h12340);
        enter5(20'h1234F);
        chk("lockout_active", int'(locked_out), 1);
        for (int i = 0; i < 20; i++) step(1'b1, $urandom_range(0, 15), (i == 7), 1'b0);
        idle(L);
        chk("post_lockout_fail_cnt", int'(fail_cnt), 0);
        chk("post_lockout_locked_out", int'(locked_out), 0);

        // Clear mid-entry, clear together with a digit
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b1, 2, 1'b0, 1'b0);
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        step(1'b1, 1, 1'b1, 1'b0);
        enter5(20'h12345);
        idle(U + 5);

        // Fire alarm during lockout, with a reset cycle inside the alarm window
        enter5(20'h55555);
        enter5(20'h55555);
        enter5(20'h55555);
        idle(50);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) rst_n = 1'b0;
            step(1'b1, 1, 1'b0, 1'b1);
            chk("fire_unlock", int'(unlock), 1);
            if (i == 5) rst_n = 1'b1;
        end
        fire_alarm = 1'b0;
        #1;
        chk("fire_release_unlock", int'(unlock), 0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("fire_after_locked_out", int'(locked_out), 0);
        chk("fire_after_fail_cnt", int'(fail_cnt), 0);

        // Reset 100 cycles into OPEN
        enter5(20'h12345);
        idle(100);
        rst_n = 1'b0;
        #1;
        chk("reset_open_unlock", int'(unlock), 0);
        model_reset();
        repeat (3) step(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        enter5(20'h12345);
        chk("reopen_unlock", int'(unlock), 1);
        idle(U + 5);

        // Randomized traffic against the model
        for (int n = 0; n < 6000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                step(1'b0, 0, 1'b1, 1'b0);
            end else if (r < 5) begin
                step(1'b1, $urandom_range(0, 15), 1'b1, 1'b0);
            end else if (r < 60) begin
                if ($urandom_range(0, 9) < 8) d = pw[entry.size()];
                else                          d = $urandom_range(0, 15);
                step(1'b1, d, 1'b0, 1'b0);
            end else begin
                step(1'b0, 0, 1'b0, 1'b0);
            end
        end
        idle(L + 10);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
# lock_controller

Sequential front end for the enhanced-security lock. It accepts keypad digits one at a time and checks them in order against a parameterised password, then holds the door unlocked for a fixed time. Repeated failures trigger a timed lockout with an alarm. The fire-alarm override from the combinational lock datapath is retained here, so this block drives the actuator directly.

## Interface
- NUM_DIGITS, 5: password length in digits (2..8).
- PASSWORD, 20'h12345: packed 4-bit BCD digits, width 4*NUM_DIGITS; first digit in the most significant nibble.
- MAX_TRIES, 3: consecutive wrong entries that trigger lockout (1..15).
- UNLOCK_CYCLES, 500: cycles the unlock output is held after a correct entry (≥1).
- LOCKOUT_CYCLES, 1000: cycles spent in lockout (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- digit_valid  in  1  one-cycle strobe: digit is a key press.
- digit  in  4  BCD key value. Values 10..15 are accepted as entries but never match.
- clear  in  1  discard the partial entry.
- fire_alarm  in  1  emergency override, level-sensitive.
- unlock  out  1  door actuator.
- err  out  1  one-cycle pulse on a wrong complete entry.
- locked_out  out  1  high throughout LOCKOUT.
- digit_cnt  out  clog2(NUM_DIGITS+1)  digits accepted in the current entry.
- fail_cnt  out  4  consecutive wrong entries.

## Operation
- States: IDLE, ENTRY, OPEN, LOCKOUT. Digits are never stored; a sticky mismatch flag accumulates the per-digit comparison.
- IDLE: a digit_valid press loads digit_cnt=1, sets mismatch = (digit != PASSWORD nibble 0) and moves to ENTRY. When NUM_DIGITS=1, the complete-entry rule below applies immediately.
- ENTRY: each press with index k (0-based) is compared against nibble k, ORs its result into mismatch, and increments digit_cnt.
- Complete entry (the press that makes digit_cnt reach NUM_DIGITS):
  - Final mismatch = 0: go to OPEN, load the timer with UNLOCK_CYCLES, clear fail_cnt.
  - Final mismatch = 1: pulse err and increment fail_cnt.
    - If the new fail_cnt equals MAX_TRIES: go to LOCKOUT and load the timer with LOCKOUT_CYCLES.
    - Otherwise: go to IDLE.
  - In every case digit_cnt returns to 0.
- OPEN: the timer decrements each cycle. On the cycle the timer reaches 1, the next state is IDLE. digit_valid and clear are ignored.
- LOCKOUT: locked_out=1 and digit_valid and clear are ignored. When the timer expires, go to IDLE and set fail_cnt=0.
- clear in IDLE or ENTRY: go to IDLE with digit_cnt=0 and mismatch=0; fail_cnt is unchanged. If clear and digit_valid are high in the same cycle, clear wins and the digit is dropped.
- fire_alarm=1: on every edge the FSM is forced to IDLE, and digit_cnt, mismatch, fail_cnt and the timer are cleared. err is suppressed and digit_valid is ignored. This takes priority over all other inputs.
- unlock = (state==OPEN) | fire_alarm. This is combinational in fire_alarm only; all other outputs are registered.
- fail_cnt saturates at MAX_TRIES and never wraps.

## Timing
- Reset values:
  - State is IDLE.
  - unlock=fire_alarm. The fire-alarm path stays live during reset.
  - err, locked_out, digit_cnt and fail_cnt are all 0.
- Reset mid-OPEN or mid-LOCKOUT aborts immediately; there is no residual unlock.
- digit_cnt updates on the edge that samples digit_valid.
- Correct entry: unlock rises on the edge that samples the final digit. It stays high for exactly UNLOCK_CYCLES cycles, then falls.
- Wrong entry: err is high for exactly the one cycle following the edge that samples the final digit.
- Lockout: locked_out rises together with that err pulse. It stays high for exactly LOCKOUT_CYCLES cycles, then falls, and fail_cnt reads 0 in the same cycle.
- Back-to-back digit_valid strobes on consecutive cycles are all accepted; there is no minimum gap between presses.
- Inputs are synchronous to clk; keypad debounce and synchronisation are done upstream.
- Falling fire_alarm: unlock falls in the same cycle and the FSM is in IDLE on the next edge.

## Test plan
- Press 1,2,3,4,5 on consecutive cycles (defaults) -> unlock high for 500 cycles starting on the edge after the 5th press; err stays 0; fail_cnt=0.
- Press 1,2,3,4,6, then 1,2,3,4,5 -> a single err pulse with fail_cnt=1; the second entry unlocks and fail_cnt returns to 0.
- Enter three wrong codes -> err pulses with fail_cnt counting 1,2,3. locked_out rises with the 3rd err and stays high 1000 cycles. Presses during lockout leave digit_cnt at 0. On exit fail_cnt=0.
- Press 1,2,3 then clear, then 1,2,3,4,5 -> digit_cnt goes 3→0; no err; the later entry unlocks. Also drive clear together with digit_valid -> the digit is dropped.
- Assert fire_alarm for 10 cycles during lockout, including a cycle with rst_n=0 -> unlock=1 for exactly those cycles; afterwards state is IDLE with fail_cnt=0 and locked_out=0.
- Assert rst_n low 100 cycles into OPEN -> unlock falls asynchronously; after release, 1,2,3,4,5 unlocks again.
